// File: rtl/serial_compare_ctrl_if.sv
// Start/abort request and busy/done/result bus for the serial slice comparator.
interface serial_compare_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             gt;
  logic             lt;
  logic             eq;

  modport master (
    output start, abort, a_in, b_in,
    input  busy, done, gt, lt, eq
  );

  modport slave (
    input  start, abort, a_in, b_in,
    output busy, done, gt, lt, eq
  );
endinterface

// File: rtl/serial_compare_ctrl.sv
// Unsigned magnitude compare of two WIDTH-bit operands, one 2-bit slice per clock,
// most significant slice first, stopping at the first differing slice.
module serial_compare_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDXW  = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  serial_compare_ctrl_if.slave bus
);

  localparam int unsigned N = WIDTH / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, a_nxt;
  logic [WIDTH-1:0] b_q, b_nxt;
  logic [IDXW-1:0]  idx, idx_nxt;
  logic             gt_q, gt_nxt;
  logic             lt_q, lt_nxt;
  logic             eq_q, eq_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic [1:0]       sa, sb;
  logic             g, l;

  // Current slice and the two 2-bit greater-than slices
  always_comb begin
    sa = a_q[{idx, 1'b0} +: 2];
    sb = b_q[{idx, 1'b0} +: 2];
    g  = (sa > sb);
    l  = (sb > sa);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      gt_q   <= 1'b0;
      lt_q   <= 1'b0;
      eq_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      a_q    <= a_nxt;
      b_q    <= b_nxt;
      idx    <= idx_nxt;
      gt_q   <= gt_nxt;
      lt_q   <= lt_nxt;
      eq_q   <= eq_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
    end
  end

  // Next-state logic; busy/done are registered decodes of the next state
  always_comb begin
    state_nxt = state;
    a_nxt     = a_q;
    b_nxt     = b_q;
    idx_nxt   = idx;
    gt_nxt    = gt_q;
    lt_nxt    = lt_q;
    eq_nxt    = eq_q;

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          a_nxt     = bus.a_in;
          b_nxt     = bus.b_in;
          idx_nxt   = IDXW'(N - 1);
          gt_nxt    = 1'b0;
          lt_nxt    = 1'b0;
          eq_nxt    = 1'b0;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_nxt = IDLE;
        end else if (g) begin
          gt_nxt    = 1'b1;
          state_nxt = DONE;
        end else if (l) begin
          lt_nxt    = 1'b1;
          state_nxt = DONE;
        end else if (idx == '0) begin
          eq_nxt    = 1'b1;
          state_nxt = DONE;
        end else begin
          idx_nxt   = idx - IDXW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == RUN);
    done_nxt = (state_nxt == DONE);
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.gt   = gt_q;
  assign bus.lt   = lt_q;
  assign bus.eq   = eq_q;

endmodule
